// File: rtl/uart_alu_pkg.sv
// Shared opcodes, header length, FSM state encoding and opcode helpers for uart_alu_ctrl.
// Honours UART_ALU_MUL_EN: when defined, opcode 0x4D is a 32-bit multiply-reduce.
package uart_alu_pkg;

    localparam logic [7:0] OPC_ECHO = 8'hEC;
    localparam logic [7:0] OPC_ADD  = 8'hAD;
    localparam logic [7:0] OPC_MUL  = 8'h4D;
    localparam int         HDR_LEN  = 4;

    typedef enum logic [2:0] {
        ST_OPCODE,
        ST_RSVD,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_ECHO,
        ST_ACC,
        ST_DRAIN,
        ST_RESP
    } state_e;

    function automatic logic is_arith(input logic [7:0] opc);
`ifdef UART_ALU_MUL_EN
        return (opc == OPC_ADD) || (opc == OPC_MUL);
`else
        return opc == OPC_ADD;
`endif
    endfunction

    function automatic logic [31:0] acc_identity(input logic [7:0] opc);
        return (opc == OPC_MUL) ? 32'd1 : 32'd0;
    endfunction

endpackage

// File: rtl/uart_alu_word_asm.sv
// Little-endian byte-to-word assembler: word/word_valid are combinational on the 4th byte
// or on a flushed byte, with the unfilled upper bytes reading as zero.
module uart_alu_word_asm (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  data,
    input  logic        data_valid,
    input  logic        flush,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [31:0] part;
    logic [1:0]  idx;

    always_comb begin
        word = part;
        word[{idx, 3'b000} +: 8] = data;
    end

    assign word_valid = data_valid && (flush || (idx == 2'd3));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            part <= '0;
            idx  <= '0;
        end else if (data_valid) begin
            if (word_valid) begin
                part <= '0;
                idx  <= '0;
            end else begin
                part <= word;
                idx  <= idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Length-framed UART command processor: echoes payload or reduces 32-bit LE words (ADD, optional MUL).
// Optional multiply opcode is enabled by defining UART_ALU_MUL_EN.
//
// state     | meaning
// ST_OPCODE | idle, waiting for opcode byte
// ST_RSVD   | skip reserved header byte
// ST_LEN_LO | capture low length byte
// ST_LEN_HI | capture high length byte, load accumulator identity, dispatch
// ST_ECHO   | forward payload bytes to TX with 1-cycle latency
// ST_ACC    | assemble payload into words and reduce into accumulator
// ST_DRAIN  | discard payload of unknown opcode
// ST_RESP   | serialise 4-byte accumulator, LSB first
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy_o
);

    if (DATA_WIDTH != 8) begin : g_bad_width
        $error("uart_alu_ctrl supports DATA_WIDTH=8 only");
    end

    state_e                state;
    logic [7:0]            opcode;
    logic [7:0]            len_lo;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [LEN_WIDTH-1:0]  cnt_inc;
    logic [LEN_WIDTH-1:0]  len_hdr;
    logic [31:0]           acc;
    logic [31:0]           acc_comb;
    logic [2:0]            resp_cnt;
    logic                  accept;
    logic                  last_byte;
    logic [31:0]           word;
    logic                  word_valid;

    always_comb begin
        case (state)
            ST_ECHO: s_axis_tready = !m_axis_tvalid || m_axis_tready;
            ST_RESP: s_axis_tready = 1'b0;
            default: s_axis_tready = 1'b1;
        endcase
    end

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign cnt_inc   = (cnt == {LEN_WIDTH{1'b1}}) ? cnt : cnt + LEN_WIDTH'(1);
    assign last_byte = cnt_inc >= len;
    assign len_hdr   = LEN_WIDTH'({s_axis_tdata, len_lo});
    assign busy_o    = state != ST_OPCODE;

    uart_alu_word_asm u_word_asm (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .data       (s_axis_tdata),
        .data_valid (accept && (state == ST_ACC)),
        .flush      (last_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        acc_comb = acc + word;
`ifdef UART_ALU_MUL_EN
        if (opcode == OPC_MUL) acc_comb = acc * word;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ST_OPCODE;
            opcode        <= '0;
            len_lo        <= '0;
            len           <= '0;
            cnt           <= '0;
            acc           <= '0;
            resp_cnt      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            // Default: a held output byte clears once the TX side takes it; loads below override.
            if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
            if (accept) cnt <= cnt_inc;

            case (state)
                ST_OPCODE: if (accept) begin
                    opcode <= s_axis_tdata;
                    cnt    <= LEN_WIDTH'(1);
                    state  <= ST_RSVD;
                end
                ST_RSVD: if (accept) state <= ST_LEN_LO;
                ST_LEN_LO: if (accept) begin
                    len_lo <= s_axis_tdata;
                    state  <= ST_LEN_HI;
                end
                ST_LEN_HI: if (accept) begin
                    len <= len_hdr;
                    acc <= acc_identity(opcode);
                    if (len_hdr <= LEN_WIDTH'(HDR_LEN))
                        state <= is_arith(opcode) ? ST_RESP : ST_OPCODE;
                    else if (opcode == OPC_ECHO)
                        state <= ST_ECHO;
                    else if (is_arith(opcode))
                        state <= ST_ACC;
                    else
                        state <= ST_DRAIN;
                end
                ST_ECHO: if (accept) begin
                    m_axis_tdata  <= s_axis_tdata;
                    m_axis_tvalid <= 1'b1;
                    if (last_byte) state <= ST_OPCODE;
                end
                ST_ACC: if (accept) begin
                    if (word_valid) acc <= acc_comb;
                    if (last_byte) state <= ST_RESP;
                end
                ST_DRAIN: if (accept && last_byte) state <= ST_OPCODE;
                ST_RESP: begin
                    if (resp_cnt != 3'd4) begin
                        if (!m_axis_tvalid || m_axis_tready) begin
                            m_axis_tdata  <= acc[{resp_cnt[1:0], 3'b000} +: 8];
                            m_axis_tvalid <= 1'b1;
                            resp_cnt      <= resp_cnt + 3'd1;
                        end
                    end else if (m_axis_tvalid && m_axis_tready) begin
                        resp_cnt <= '0;
                        acc      <= acc_identity(opcode);
                        state    <= ST_OPCODE;
                    end
                end
                default: state <= ST_OPCODE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: directed packets plus randomized packets vs a packet-level model.
// Follows UART_ALU_MUL_EN to decide whether opcode 0x4D is expected to respond.
module tb_uart_alu_ctrl;

`ifdef UART_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic       busy_o;

    int total = 0;
    int bad = 0;
    int rdy_mode = 0;
    int gap_max = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pkt_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    uart_alu_ctrl dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(posedge clk_i) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = !m_tready;
            2:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
    end

    // Output monitor and hold-while-stalled protocol check.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(m_tvalid), 32'd1);
                chk("hold_data", 32'(m_tdata), 32'(prev_data));
            end
            if (m_tvalid && m_tready) got_q.push_back(m_tdata);
        end
        prev_stall = rst_ni && m_tvalid && !m_tready;
        prev_data  = m_tdata;
    end

    function automatic void model(input logic [7:0] p[$]);
        int len, plen;
        logic [31:0] acc, word;
        logic mul;
        len  = int'({p[3], p[2]});
        plen = (len > 4) ? len - 4 : 0;
        mul  = MUL_EN && (p[0] == 8'h4D);
        if (p[0] == 8'hEC) begin
            for (int i = 0; i < plen; i++) exp_q.push_back(p[4+i]);
        end else if (p[0] == 8'hAD || mul) begin
            acc = mul ? 32'd1 : 32'd0;
            for (int i = 0; i < plen; i += 4) begin
                word = 0;
                for (int j = 0; j < 4; j++)
                    if (i + j < plen) word = word | (32'(p[4+i+j]) << (8 * j));
                acc = mul ? acc * word : acc + word;
            end
            for (int j = 0; j < 4; j++) exp_q.push_back(8'(acc >> (8 * j)));
        end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        repeat ($urandom_range(0, gap_max)) begin @(posedge clk_i); #1; end
        s_tdata  = b;
        s_tvalid = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!s_tready && n < 3000) begin @(negedge clk_i); n++; end
        if (n >= 3000) chk("rx_stall", 32'(n), 32'd0);
        @(posedge clk_i); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] p[$]);
        foreach (p[i]) send_byte(p[i]);
    endtask

    task automatic expect_pkt(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 2000) begin @(posedge clk_i); #1; n++; end
        repeat (12) begin @(posedge clk_i); #1; end
        chk({tag, "_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int len;
        logic [7:0] opc;

        #500_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        logic [7:0] opc;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd1);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        pkt_q = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        exp_q = '{8'h41, 8'h42, 8'h43};
        send_pkt(pkt_q); expect_pkt("echo");

        pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt_q); expect_pkt("add_wrap");

        pkt_q = '{8'hAD, 8'h00, 8'h06, 8'h00, 8'h34, 8'h12};
        exp_q = '{8'h34, 8'h12, 8'h00, 8'h00};
        send_pkt(pkt_q); expect_pkt("add_part");

        pkt_q = '{8'hAD, 8'h00, 8'h04, 8'h00};
        exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt_q); expect_pkt("add_empty");

        pkt_q = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        send_pkt(pkt_q); expect_pkt("unknown");
        pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        exp_q = '{8'h5A};
        send_pkt(pkt_q); expect_pkt("echo_after_unk");

        pkt_q = '{8'h4D, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        if (MUL_EN) exp_q = '{8'h0F, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt_q); expect_pkt("mul");

        // Stalled output register must hold data and stop RX.
        rdy_mode = 3;
        pkt_q = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h11};
        send_pkt(pkt_q);
        @(negedge clk_i);
        chk("bp_tvalid", 32'(m_tvalid), 32'd1);
        chk("bp_tdata", 32'(m_tdata), 32'h11);
        chk("bp_tready", 32'(s_tready), 32'd0);
        @(posedge clk_i); #1;
        rdy_mode = 1;
        send_byte(8'h22);
        exp_q = '{8'h11, 8'h22};
        expect_pkt("bp_echo");

        pkt_q = '{8'hEC, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_pkt(pkt_q); expect_pkt("bp_toggle");

        // Reset while a payload byte is held in the output register.
        rdy_mode = 3;
        pkt_q = '{8'hEC, 8'h00, 8'h10, 8'h00, 8'h01};
        send_pkt(pkt_q);
        @(negedge clk_i);
        chk("pre_rst_tvalid", 32'(m_tvalid), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        rdy_mode = 0;
        @(posedge clk_i); #1;
        got_q.delete();
        pkt_q = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h77, 8'h88};
        exp_q = '{8'h77, 8'h88};
        send_pkt(pkt_q); expect_pkt("post_rst");

        gap_max = 2;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0:       opc = 8'hEC;
                1:       opc = 8'hAD;
                2:       opc = 8'h4D;
                default: opc = 8'($urandom_range(0, 255));
            endcase
            len = $urandom_range(0, 26);
            pkt_q.delete();
            pkt_q.push_back(opc);
            pkt_q.push_back(8'($urandom));
            pkt_q.push_back(8'(len));
            pkt_q.push_back(8'(len >> 8));
            for (int i = 4; i < len; i++) pkt_q.push_back(8'($urandom));
            model(pkt_q);
            rdy_mode = $urandom_range(0, 2);
            send_pkt(pkt_q);
            expect_pkt("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
Byte-stream command processor between the UART receiver's AXI-Stream master and the UART transmitter's AXI-Stream slave. It parses length-framed packets: opcode, reserved byte, 16-bit little-endian total length, then payload. It either echoes the payload or reduces 32-bit little-endian operands with the ALU and returns a 4-byte result. There is one clock domain and no internal FIFO; back-pressure propagates through the ready signals.

Parameters:
DATA_WIDTH, 8, stream byte width; only 8 is supported and other values are a synthesis error.
LEN_WIDTH, 16, width of the packet length field and the byte counter.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; asynchronous assert, active-low, synchronous deassert expected externally
s_axis_tdata  input  8  byte from UART RX
s_axis_tvalid  input  1  RX byte valid
s_axis_tready  output  1  block accepts byte
m_axis_tdata  output  8  byte to UART TX
m_axis_tvalid  output  1  output byte valid
m_axis_tready  input  1  TX accepts byte
busy_o  output  1  state is not ST_OPCODE

Behaviour:
- Reset: state ST_OPCODE; m_axis_tvalid=0; m_axis_tdata=0; accumulator=0; byte counter=0; s_axis_tready=1 after reset.
- Handshakes:
  - A byte transfers when valid&&ready on the clock edge.
  - m_axis_tdata/tvalid are registered and hold stable until accepted.
- Header path ST_OPCODE -> ST_RSVD -> ST_LEN_LO -> ST_LEN_HI:
  - One accepted byte per state; s_axis_tready=1 throughout.
  - The opcode is latched; the reserved byte is ignored.
  - The byte counter counts accepted bytes of the packet, including the header.
- Leaving ST_LEN_HI, where len = {hi,lo}:
  - len<=4: no payload, so the packet ends. ADD (and MUL if enabled) still go to ST_RESP; ECHO and unknown opcodes return to ST_OPCODE.
  - len>4:
    - ECHO goes to ST_ECHO.
    - ADD/MUL go to ST_ACC.
    - Unknown opcodes go to ST_DRAIN.
- ST_ECHO:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - Each accepted byte is loaded into the output register the same edge, giving 1-cycle latency.
  - Moves to ST_OPCODE on the byte where counter reaches len.
- ST_ACC:
  - s_axis_tready=1.
  - Bytes are assembled LSB-first into a 32-bit word; each completed word is combined into the accumulator.
  - ADD: acc = acc + word, wrapping mod 2^32.
  - On the final packet byte, a partial word is zero-extended and combined. The next state is ST_RESP.
- ST_RESP:
  - s_axis_tready=0.
  - Emits acc bytes 0..3, LSB first, one per accepted output handshake.
  - After byte 3 is accepted, returns to ST_OPCODE and the accumulator is reloaded with its opcode's identity.
- ST_DRAIN: s_axis_tready=1; payload is discarded; no output; returns to ST_OPCODE at counter==len.
- Accumulator identity: ADD=0, MUL=1. It is loaded in ST_LEN_HI, so ADD with no payload returns 00 00 00 00.
- The counter saturates at 2^LEN_WIDTH-1, and the maximum packet is 65535 bytes.
- No timeout exists; a stalled RX leaves the block waiting in its current state.
- Reset mid-packet: all state is discarded immediately, and a pending output byte is dropped (tvalid falls asynchronously).

Optional Feature:
- Macro: UART_ALU_MUL_EN.
- Defined: opcode 0x4D is MUL, acc = acc * word mod 2^32, identity 1, response as ADD. The multiply is a single-cycle combinational multiply registered into acc.
- Undefined: 0x4D is an unknown opcode and is drained with no response; no multiplier is inferred.

Decomposition:
- Package uart_alu_pkg holds:
  - opcode constants OPC_ECHO=8'hEC, OPC_ADD=8'hAD, OPC_MUL=8'h4D;
  - HDR_LEN=4;
  - state enum state_e {ST_OPCODE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_ECHO, ST_ACC, ST_DRAIN, ST_RESP}.
- Sub-module uart_alu_word_asm: byte-to-32-bit little-endian assembler with a word_valid pulse and a final-flush input; the top owns the FSM, accumulator and response serialiser.

Test Plan:
- ECHO: EC 00 07 00 41 42 43, tready held 1 -> output 41 42 43, busy_o low after last byte.
- ADD: AD 00 0C 00 + words 00000001, FFFFFFFF -> output 00 00 00 00 (wrap).
- ADD partial word: AD 00 06 00 34 12 -> output 34 12 00 00.
- ADD empty: AD 00 04 00 -> output 00 00 00 00. Unknown opcode: 55 00 06 00 AA BB -> no output, and the next ECHO packet works.
- Back-pressure: ECHO of 8 bytes with m_axis_tready toggling 1/0 -> s_axis_tready low whenever the output register is full and stalled, with no loss or duplication. Reset asserted mid-payload -> tvalid=0 and the next packet parses cleanly.
- With UART_ALU_MUL_EN: 4D 00 0C 00 + 00000003, 00000005 -> output 0F 00 00 00. Without the macro, the same packet -> no output.
